// File: rtl/regfile_pkg.sv
// Shared types and default widths for the register-file writeback arbiter.
// Consumers import regfile_pkg::* for the register address/data types.
package regfile_pkg;

   localparam int DEF_ADDRESS_WIDTH = 5;
   localparam int DEF_DATA_WIDTH    = 32;
   localparam int DEF_NUM_REQ       = 3;
   localparam int NUM_REGS          = 2 ** DEF_ADDRESS_WIDTH;

   typedef logic [DEF_ADDRESS_WIDTH-1:0] reg_addr_t;
   typedef logic [DEF_DATA_WIDTH-1:0]    reg_data_t;

   typedef struct packed {
      logic      valid;
      reg_addr_t addr;
      reg_data_t data;
   } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback requester bus, decode issue port, register-file write port and scoreboard.
// The arbiter takes the slave side; the execute/decode/regfile environment takes the master side.
interface regfile_wb_arbiter_if #(
   parameter int ADDRESS_WIDTH = regfile_pkg::DEF_ADDRESS_WIDTH,
   parameter int DATA_WIDTH    = regfile_pkg::DEF_DATA_WIDTH,
   parameter int NUM_REQ       = regfile_pkg::DEF_NUM_REQ
);
   logic [NUM_REQ-1:0]               req_valid_i;
   logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr_i;
   logic [NUM_REQ*DATA_WIDTH-1:0]    req_data_i;
   logic [NUM_REQ-1:0]               req_ready_o;
   logic                             issue_valid_i;
   logic [ADDRESS_WIDTH-1:0]         issue_addr_i;
   logic                             rf_we_o;
   logic [ADDRESS_WIDTH-1:0]         rf_addr_o;
   logic [DATA_WIDTH-1:0]            rf_wd_o;
   logic [2**ADDRESS_WIDTH-1:0]      pending_o;

   modport slave (
      input  req_valid_i, req_addr_i, req_data_i, issue_valid_i, issue_addr_i,
      output req_ready_o, rf_we_o, rf_addr_o, rf_wd_o, pending_o
   );

   modport master (
      output req_valid_i, req_addr_i, req_data_i, issue_valid_i, issue_addr_i,
      input  req_ready_o, rf_we_o, rf_addr_o, rf_wd_o, pending_o
   );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Combinational rotating-priority arbiter: the search begins at ptr_i and wraps.
// Holding ptr_i at zero turns it into a fixed lowest-index-wins arbiter.
module wb_rr_arbiter #(
   parameter  int NUM_REQ = 3,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [IDX_W-1:0]   idx_o,
   output logic               any_o
);

   always_comb begin
      int j;
      j       = 0;
      grant_o = '0;
      idx_o   = '0;
      any_o   = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         j = (int'(ptr_i) + i) % NUM_REQ;
         if (!any_o && req_i[j]) begin
            any_o      = 1'b1;
            grant_o[j] = 1'b1;
            idx_o      = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among NUM_REQ writeback units and keeps the pending-write scoreboard.
// Round-robin when WB_ARB_RR_EN is defined, otherwise fixed lowest-index priority; one-cycle registered write.
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
   parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter int NUM_REQ       = DEF_NUM_REQ
) (
   input logic                clk_i,
   input logic                rst_i,
   regfile_wb_arbiter_if.slave bus
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int NREGS = 2 ** ADDRESS_WIDTH;

   logic [NUM_REQ-1:0]       grant;
   logic [IDX_W-1:0]         grant_idx;
   logic                     grant_any;
   logic [IDX_W-1:0]         rr_ptr;
   logic                     accept;
   logic                     wr_en;
   logic [ADDRESS_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0]    sel_data;

   logic                     rf_we_q, rf_we_d;
   logic [ADDRESS_WIDTH-1:0] rf_addr_q, rf_addr_d;
   logic [DATA_WIDTH-1:0]    rf_wd_q, rf_wd_d;
   logic [NREGS-1:0]         pending_q, pending_d;

   wb_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req_i   (bus.req_valid_i),
      .ptr_i   (rr_ptr),
      .grant_o (grant),
      .idx_o   (grant_idx),
      .any_o   (grant_any)
   );

   // The register file takes a write every cycle, so a grant is always an acceptance.
   assign accept          = grant_any & ~rst_i;
   assign bus.req_ready_o = grant & {NUM_REQ{~rst_i}};
   assign sel_addr        = bus.req_addr_i[int'(grant_idx)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
   assign sel_data        = bus.req_data_i[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
   assign wr_en           = accept && (sel_addr != '0);

`ifdef WB_ARB_RR_EN
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (accept)
         rr_ptr_d = (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) rr_ptr_q <= '0;
      else       rr_ptr_q <= rr_ptr_d;
   end

   assign rr_ptr = rr_ptr_q;
`else
   assign rr_ptr = '0;
`endif

   always_comb begin
      rf_we_d   = wr_en;
      rf_addr_d = rf_addr_q;
      rf_wd_d   = rf_wd_q;
      pending_d = pending_q;
      if (wr_en) begin
         rf_addr_d           = sel_addr;
         rf_wd_d             = sel_data;
         pending_d[sel_addr] = 1'b0;
      end
      // Set after clear: a fresh issue supersedes the producer retiring this cycle.
      if (bus.issue_valid_i && (bus.issue_addr_i != '0))
         pending_d[bus.issue_addr_i] = 1'b1;
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rf_we_q   <= 1'b0;
         rf_addr_q <= '0;
         rf_wd_q   <= '0;
         pending_q <= '0;
      end else begin
         rf_we_q   <= rf_we_d;
         rf_addr_q <= rf_addr_d;
         rf_wd_q   <= rf_wd_d;
         pending_q <= pending_d;
      end
   end

   assign bus.rf_we_o   = rf_we_q;
   assign bus.rf_addr_o = rf_addr_q;
   assign bus.rf_wd_o   = rf_wd_q;
   assign bus.pending_o = pending_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter; expectations follow WB_ARB_RR_EN when it is defined.
module tb_regfile_wb_arbiter;
   import regfile_pkg::*;

   logic clk;
   logic rst;
   logic proto_en;
   logic [2:0] prev_wait;
   int n_chk;
   int n_pass;

   regfile_wb_arbiter_if #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .NUM_REQ(3)) bus ();

   regfile_wb_arbiter #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .NUM_REQ(3)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
   endtask

   // A requester left waiting at an edge must still be valid at the next edge.
   always @(posedge clk) begin
      if (proto_en && !rst) begin
         n_chk++;
         assert ((prev_wait & ~bus.req_valid_i) == 3'b000) n_pass++;
         else $error("FAIL proto_valid_drop: got 0x%0h required 0x0", prev_wait & ~bus.req_valid_i);
      end
      prev_wait <= rst ? 3'b000 : (bus.req_valid_i & ~bus.req_ready_o);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int k, input reg_addr_t a, input reg_data_t d);
      bus.req_valid_i[k]          = 1'b1;
      bus.req_addr_i[k*5 +: 5]    = a;
      bus.req_data_i[k*32 +: 32]  = d;
   endtask

   task automatic clr_reqs();
      bus.req_valid_i = '0;
      bus.req_addr_i  = '0;
      bus.req_data_i  = '0;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      #1;
      rst = 1'b0;
   endtask

   initial begin
      int exp_k;
      logic [2:0] exp_g;
      n_chk    = 0;
      n_pass   = 0;
      proto_en = 1'b0;
      rst      = 1'b1;
      clr_reqs();
      bus.issue_valid_i = 1'b0;
      bus.issue_addr_i  = '0;

      // Reset state, with all requesters valid to show ready is held low.
      bus.req_valid_i = 3'b111;
      #12;
      chk("rst_we", bus.rf_we_o, 0);
      chk("rst_addr", bus.rf_addr_o, 0);
      chk("rst_wd", bus.rf_wd_o, 0);
      chk("rst_pending", bus.pending_o, 0);
      chk("rst_ready", bus.req_ready_o, 0);
      clr_reqs();
      rst      = 1'b0;
      proto_en = 1'b1;

      // Single write from requester 1.
      set_req(1, 5'd5, 32'hDEADBEEF);
      #1 chk("single_ready", bus.req_ready_o, 3'b010);
      tick();
      chk("single_we", bus.rf_we_o, 1);
      chk("single_addr", bus.rf_addr_o, 5);
      chk("single_wd", bus.rf_wd_o, 32'hDEADBEEF);
      clr_reqs();
      #1 chk("single_ready_off", bus.req_ready_o, 0);
      tick();
      chk("single_we_off", bus.rf_we_o, 0);

      // Contention from a freshly reset pointer.
      pulse_reset();
      for (int k = 0; k < 3; k++) set_req(k, reg_addr_t'(k + 1), 32'h100 + k);
      for (int i = 0; i < 6; i++) begin
`ifdef WB_ARB_RR_EN
         exp_k = i % 3;
`else
         exp_k = 0;
`endif
         exp_g = 3'b001 << exp_k;
         #1 chk($sformatf("cont_ready_%0d", i), bus.req_ready_o, exp_g);
         tick();
         chk($sformatf("cont_we_%0d", i), bus.rf_we_o, 1);
         chk($sformatf("cont_addr_%0d", i), bus.rf_addr_o, exp_k + 1);
         chk($sformatf("cont_wd_%0d", i), bus.rf_wd_o, 32'h100 + exp_k);
      end
      proto_en = 1'b0;
      clr_reqs();
      tick();
      chk("cont_idle_we", bus.rf_we_o, 0);
      proto_en = 1'b1;

      // Scoreboard set on issue, cleared on writeback.
      bus.issue_valid_i = 1'b1;
      bus.issue_addr_i  = 5'd7;
      tick();
      bus.issue_valid_i = 1'b0;
      chk("sb_set7", bus.pending_o, 32'h0000_0080);
      set_req(0, 5'd7, 32'h77);
      #1 chk("sb_ready7", bus.req_ready_o, 3'b001);
      tick();
      clr_reqs();
      chk("sb_we7", bus.rf_we_o, 1);
      chk("sb_clr7", bus.pending_o, 0);

      // Same-edge set and clear on register 9: set wins.
      bus.issue_valid_i = 1'b1;
      bus.issue_addr_i  = 5'd9;
      tick();
      chk("col_pre", bus.pending_o, 32'h0000_0200);
      set_req(2, 5'd9, 32'h99);
      tick();
      bus.issue_valid_i = 1'b0;
      clr_reqs();
      chk("col_pending", bus.pending_o, 32'h0000_0200);
      chk("col_we", bus.rf_we_o, 1);
      chk("col_addr", bus.rf_addr_o, 9);
      set_req(2, 5'd9, 32'h98);
      tick();
      clr_reqs();
      chk("col_drain", bus.pending_o, 0);

      // Register 0 is acknowledged but never written nor tracked.
      set_req(1, 5'd0, 32'h1234);
      bus.issue_valid_i = 1'b1;
      bus.issue_addr_i  = 5'd0;
      #1 chk("r0_ready", bus.req_ready_o, 3'b010);
      tick();
      clr_reqs();
      bus.issue_valid_i = 1'b0;
      chk("r0_we", bus.rf_we_o, 0);
      chk("r0_pending", bus.pending_o, 0);

      // Asynchronous reset while a write is in flight and 0x84 is pending.
      bus.issue_valid_i = 1'b1;
      bus.issue_addr_i  = 5'd2;
      tick();
      bus.issue_addr_i  = 5'd7;
      set_req(0, 5'd5, 32'h55);
      tick();
      bus.issue_valid_i = 1'b0;
      chk("ar_pre_we", bus.rf_we_o, 1);
      chk("ar_pre_pending", bus.pending_o, 32'h0000_0084);
      #2 rst = 1'b1;
      #1;
      chk("ar_we", bus.rf_we_o, 0);
      chk("ar_pending", bus.pending_o, 0);
      chk("ar_ready", bus.req_ready_o, 0);
      #1 rst = 1'b0;
      for (int k = 0; k < 3; k++) set_req(k, reg_addr_t'(k + 1), 32'h200 + k);
      #1 chk("ar_ptr0", bus.req_ready_o, 3'b001);
      tick();
`ifdef WB_ARB_RR_EN
      chk("ar_ptr1", bus.req_ready_o, 3'b010);
`else
      chk("ar_ptr1", bus.req_ready_o, 3'b001);
`endif
      chk("ar_post_addr", bus.rf_addr_o, 1);
      proto_en = 1'b0;
      clr_reqs();
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (we/addr/wd) between NUM_REQ writeback requesters, e.g. ALU, load unit and mul/div.
- Holds a pending-write scoreboard: one bit per architectural register, set at issue and cleared at writeback. The decode stage reads it for hazard stalls.
- Sits between the execute/writeback units and the register file. Registered output stage.

Parameters:
- ADDRESS_WIDTH, 5, register index width; the register file has 2**ADDRESS_WIDTH entries.
- DATA_WIDTH, 32, writeback data width.
- NUM_REQ, 3, number of writeback requesters (2..8).

Ports:
- clk_i  in  1  clock, all state updates on posedge.
- rst_i  in  1  asynchronous active-high reset.
- req_valid_i  in  NUM_REQ  requester k has a write pending.
- req_addr_i  in  NUM_REQ*ADDRESS_WIDTH  destination register; slice k belongs to requester k.
- req_data_i  in  NUM_REQ*DATA_WIDTH  write data; slice k belongs to requester k.
- req_ready_o  out  NUM_REQ  grant, one-hot or zero.
- issue_valid_i  in  1  decode issued an instruction with a destination register.
- issue_addr_i  in  ADDRESS_WIDTH  that destination register.
- rf_we_o  out  1  register-file write enable.
- rf_addr_o  out  ADDRESS_WIDTH  register-file write address.
- rf_wd_o  out  DATA_WIDTH  register-file write data.
- pending_o  out  2**ADDRESS_WIDTH  scoreboard; bit r=1 means a write to register r is outstanding.

Behaviour:

Reset (async assert, sync deassert by the surrounding logic):
- rf_we_o=0, rf_addr_o=0, rf_wd_o=0.
- pending_o=0.
- Round-robin pointer = 0.
- req_ready_o=0 while rst_i=1.

Arbitration (combinational):
- req_ready_o[k]=1 for exactly one valid k, selected by the arbitration policy.
- The output stage is always free, because the register file accepts one write every cycle. An accepted write therefore never stalls.
- A transfer happens on the posedge where valid[k] and ready[k] are both 1.
- Requester k must hold valid, addr and data stable until accepted. Dropping valid before acceptance is illegal; the bench asserts on it.

Latency:
- Accept at edge N gives rf_we_o=1 with the latched addr/data during cycle N..N+1. Exactly 1 cycle.
- rf_we_o=0 in any cycle following an edge with no acceptance.
- Sustained throughput is one write per cycle.

Address 0:
- A request to register 0 is accepted normally, so the requester is released.
- rf_we_o stays 0 for it and the scoreboard is untouched.

Scoreboard:
- Issue: on an edge with issue_valid_i=1 and issue_addr_i!=0, set pending[issue_addr_i].
- Accept: on an edge with an accepted write to a!=0, clear pending[a].
- Same register, same edge (set and clear): the set wins, because the new producer supersedes the old one.
- Issuing to an already-pending register keeps the bit set. No counting: one outstanding producer per register is guaranteed upstream, and decode stalls on pending.
- pending_o[0] is always 0.

Reset mid-operation:
- All state clears immediately.
- Any in-flight write in the output stage is discarded, so rf_we_o drops asynchronously.

Optional Feature:
- Macro: WB_ARB_RR_EN.
- Defined: round-robin arbitration.
  - The search starts at the pointer. After a grant to k, pointer = (k+1) mod NUM_REQ.
  - Pointer unchanged when there is no grant.
  - Guarantees each continuously-valid requester is granted within NUM_REQ cycles.
- Undefined: fixed priority, lowest index wins.
  - No pointer register exists.

Decomposition:
- Shared package regfile_pkg:
  - ADDRESS_WIDTH/DATA_WIDTH defaults.
  - typedef reg_addr_t and reg_data_t.
  - typedef wb_req_t struct {valid, addr, data}.
  - localparam NUM_REGS = 2**ADDRESS_WIDTH.
- Sub-module wb_rr_arbiter:
  - Inputs: request vector and pointer. Outputs: one-hot grant and encoded index.
  - Pure combinational.
  - Instantiated once; in fixed mode it is fed pointer=0.
- Scoreboard and output register stay in the top module.

Test Plan:
- Single write: reset; req_valid_i[1]=1, addr=5, data=0xDEADBEEF. Response: ready[1]=1 that cycle; next cycle rf_we_o=1, rf_addr_o=5, rf_wd_o=0xDEADBEEF; the following cycle rf_we_o=0.
- Contention, RR enabled: all 3 requesters valid for 6 cycles with addrs 1/2/3. Response: grant order 0,1,2,0,1,2; each write appears on the rf port one cycle later. Fixed mode with the same stimulus: requester 0 is granted every cycle and requesters 1 and 2 are never granted.
- Scoreboard: issue addr 7. Response: pending_o[7]=1 next cycle. Then a write to 7 is accepted: pending_o[7]=0 in the same cycle that rf_we_o=1.
- Set/clear collision: pending[9]=1; in one cycle issue addr 9 and accept a write to 9. Response: pending_o[9] remains 1 and rf_we_o=1 with addr 9.
- Register 0: request addr 0, data 0x1234, and issue addr 0. Response: ready asserted; rf_we_o stays 0; pending_o all-zero.
- Async reset mid-stream: assert rst_i between edges while rf_we_o=1 and pending_o=0x0000_0084. Response: rf_we_o=0 and pending_o=0 immediately; the RR pointer restarts at 0 after release.
